sdm_adc_multi: RTL and testbench

// Multi-channel successor to the single-channel SDM-to-PCM front end. It takes NCH parallel 1-bit

---
 rtl/sdm_adc_multi_if.sv | 17 +
 rtl/sdm_adc_multi.sv | 209 ++++++++++++++++++++
 tb/tb_sdm_adc_multi.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdm_adc_multi_if.sv
// Stream bundle of the multi-channel SDM front end: per-channel SDM bits in,
// channel-tagged PCM samples out over valid/ready.
interface sdm_adc_multi_if #(
    parameter int NCH   = 2,
    parameter int OUT_W = 16,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                    valid_in;
    logic [NCH-1:0]          din;
    logic                    ready_in;
    logic                    valid_out;
    logic signed [OUT_W-1:0] dout;
    logic [CHW-1:0]          dout_ch;

    modport slave  (input valid_in, din, ready_in, output valid_out, dout, dout_ch);
    modport master (output valid_in, din, ready_in, input valid_out, dout, dout_ch);
endinterface

// File: rtl/sdm_adc_multi.sv
// Multi-channel SDM-to-PCM front end: per-channel CIC integrators, one shared comb datapath
// walked channel by channel, saturating scaler and a channel-tagged output FIFO.
module sdm_adc_multi #(
    parameter int NCH        = 2,
    parameter int ORDER      = 3,
    parameter int LOG2R      = 5,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    sdm_adc_multi_if.slave bus,
    input  logic           ovr_clr,
    output logic           overrun
);
    localparam int ACC_W = ORDER * LOG2R + 32'sd2;
    localparam int R     = 32'sd1 << LOG2R;
    localparam int SHIFT = ORDER * LOG2R - OUT_W + 32'sd1;
    localparam int CHW   = (NCH > 32'sd1) ? $clog2(NCH) : 32'sd1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int WW    = $clog2(ORDER + 32'sd1);

    localparam logic signed [ACC_W-1:0] STEP_P = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] STEP_N = {ACC_W{1'b1}};
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    if (R < NCH + 32'sd2) begin : g_chk_ratio
        $error("sdm_adc_multi: decimation ratio must be at least NCH+2");
    end
    if (ORDER * LOG2R < OUT_W - 32'sd1) begin : g_chk_width
        $error("sdm_adc_multi: ORDER*LOG2R must be at least OUT_W-1");
    end
    if (FIFO_DEPTH < 32'sd2 || (FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0) begin : g_chk_depth
        $error("sdm_adc_multi: FIFO_DEPTH must be a power of two >= 2");
    end

    function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W-1:0] sh;
        sh = y >>> SHIFT;
        if (sh > SAT_HI) begin
            scale_sat = SAT_HI[OUT_W-1:0];
        end else if (sh < SAT_LO) begin
            scale_sat = SAT_LO[OUT_W-1:0];
        end else begin
            scale_sat = sh[OUT_W-1:0];
        end
    endfunction

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COMB = 1'b1} state_t;

    logic signed [ACC_W-1:0] integ_r     [NCH][ORDER];
    logic signed [ACC_W-1:0] integ_nxt_s [NCH][ORDER];
    logic signed [ACC_W-1:0] snap_r      [NCH];
    logic signed [ACC_W-1:0] cdly_r      [NCH][ORDER];
    logic signed [ACC_W-1:0] comb_in_s   [ORDER];
    logic signed [ACC_W-1:0] comb_y_s;
    logic [LOG2R-1:0]        dec_cnt_r;
    logic                    snap_pend_r;
    state_t                  state_r;
    logic [CHW-1:0]          ch_r;
    logic [WW-1:0]           warm_r;

    logic signed [OUT_W-1:0] mem_r    [FIFO_DEPTH];
    logic [CHW-1:0]          mem_ch_r [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [AW:0]             fifo_cnt_r, occ_s;
    logic                    valid_out_r, overrun_r;
    logic signed [OUT_W-1:0] dout_r;
    logic [CHW-1:0]          dout_ch_r;
    logic                    push_s, full_s, push_ok_s, drop_s, load_s;
    logic signed [OUT_W-1:0] push_data_s;

    // Integrator chain: each stage adds the already-updated value of the stage before it.
    always_comb begin
        logic signed [ACC_W-1:0] acc_v;
        for (int c = 0; c < NCH; c++) begin
            acc_v = integ_r[c][0] + (bus.din[c] ? STEP_P : STEP_N);
            integ_nxt_s[c][0] = acc_v;
            for (int s = 1; s < ORDER; s++) begin
                acc_v = integ_r[c][s] + acc_v;
                integ_nxt_s[c][s] = acc_v;
            end
        end
    end

    // Integrators, decimation counter and snapshot bank advance only on accepted SDM bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_cnt_r   <= '0;
            snap_pend_r <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                snap_r[c] <= '0;
                for (int s = 0; s < ORDER; s++) integ_r[c][s] <= '0;
            end
        end else begin
            snap_pend_r <= bus.valid_in && (&dec_cnt_r);
            if (bus.valid_in) begin
                dec_cnt_r <= dec_cnt_r + LOG2R'(1'b1);
                integ_r   <= integ_nxt_s;
                if (&dec_cnt_r) begin
                    for (int c = 0; c < NCH; c++) snap_r[c] <= integ_nxt_s[c][ORDER-1];
                end
            end
        end
    end

    // Shared comb cascade for the channel the sequencer is visiting.
    always_comb begin
        logic signed [ACC_W-1:0] acc_v;
        acc_v = snap_r[ch_r];
        for (int s = 0; s < ORDER; s++) begin
            comb_in_s[s] = acc_v;
            acc_v = acc_v - cdly_r[ch_r][s];
        end
        comb_y_s = acc_v;
    end

    assign push_s      = (state_r == ST_COMB) && (warm_r == '0);
    assign push_data_s = scale_sat(comb_y_s);

    // Frame sequencer: one channel per cycle, comb delay update and warm-up countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ch_r    <= '0;
            warm_r  <= WW'(ORDER);
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < ORDER; s++) cdly_r[c][s] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (snap_pend_r) begin
                        state_r <= ST_COMB;
                        ch_r    <= '0;
                    end
                end
                ST_COMB: begin
                    for (int s = 0; s < ORDER; s++) cdly_r[ch_r][s] <= comb_in_s[s];
                    if (ch_r == CHW'(NCH - 1)) begin
                        state_r <= ST_IDLE;
                        ch_r    <= '0;
                        if (warm_r != '0) warm_r <= warm_r - WW'(1'b1);
                    end else begin
                        ch_r <= ch_r + CHW'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ch_r    <= '0;
                end
            endcase
        end
    end

    // Occupancy includes the output register, so a pop frees room for a same-cycle push.
    assign occ_s     = fifo_cnt_r + {{AW{1'b0}}, valid_out_r};
    assign full_s    = (occ_s == (AW + 1)'(FIFO_DEPTH)) && !(valid_out_r && bus.ready_in);
    assign push_ok_s = push_s && !full_s;
    assign drop_s    = push_s && full_s;
    assign load_s    = (fifo_cnt_r != '0) && (!valid_out_r || bus.ready_in);

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r]    <= push_data_s;
            mem_ch_r[wr_ptr_r] <= ch_r;
        end
    end

    // FIFO pointers, registered output stage and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fifo_cnt_r  <= '0;
            valid_out_r <= 1'b0;
            dout_r      <= '0;
            dout_ch_r   <= '0;
            overrun_r   <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (load_s) begin
                rd_ptr_r    <= rd_ptr_r + AW'(1'b1);
                valid_out_r <= 1'b1;
                dout_r      <= mem_r[rd_ptr_r];
                dout_ch_r   <= mem_ch_r[rd_ptr_r];
            end else if (bus.ready_in) begin
                valid_out_r <= 1'b0;
            end
            case ({push_ok_s, load_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (AW + 1)'(1'b1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (AW + 1)'(1'b1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.valid_out = valid_out_r;
    assign bus.dout      = dout_r;
    assign bus.dout_ch   = dout_ch_r;
    assign overrun       = overrun_r;
endmodule

// File: tb/tb_sdm_adc_multi.sv
// Scoreboard bench for sdm_adc_multi: the driver queues hand-computed samples per frame and a
// negedge monitor pops and compares on each valid/ready transfer.
module tb_sdm_adc_multi;
    logic clk = 1'b0;
    logic reset;
    logic ovr_clr;
    logic overrun;

    sdm_adc_multi_if #(.NCH(2), .OUT_W(16)) bif ();

    sdm_adc_multi #(.NCH(2), .ORDER(3), .LOG2R(5), .OUT_W(16), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bif),
        .ovr_clr (ovr_clr),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0]         ch;
        logic signed [15:0] val;
    } exp_t;

    exp_t               q[$];
    exp_t               e;
    int                 checks = 0;
    int                 fails = 0;
    int                 cyc = 0;
    int                 frame_no = 0;
    bit                 suppress = 1'b0;
    int                 t0_prev = 0;
    int                 t0_last = 0;
    bit                 stall_prev = 1'b0;
    logic signed [15:0] hold_dout;
    logic [0:0]         hold_ch;

    always @(posedge clk) cyc++;

    // Monitor: hold-stability during stalls and scoreboard comparison on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!bif.valid_out || bif.dout !== hold_dout || bif.dout_ch !== hold_ch) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b ch=%0d dout=%0d, required v=1 ch=%0d dout=%0d",
                             bif.valid_out, bif.dout_ch, bif.dout, hold_ch, hold_dout);
                end
            end
            stall_prev = bif.valid_out && !bif.ready_in;
            hold_dout  = bif.dout;
            hold_ch    = bif.dout_ch;
            if (bif.valid_out && bif.ready_in) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got ch=%0d dout=%0d, required no output",
                             bif.dout_ch, bif.dout);
                end else begin
                    e = q.pop_front();
                    if (bif.dout_ch !== e.ch || bif.dout !== e.val) begin
                        fails++;
                        $display("FAIL sample: got ch=%0d dout=%0d, required ch=%0d dout=%0d",
                                 bif.dout_ch, bif.dout, e.ch, e.val);
                    end
                end
                if (bif.dout_ch == 1'b0) begin
                    t0_prev = t0_last;
                    t0_last = cyc;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bif.valid_in = 1'b0;
        tick(2);
        reset = 1'b0;
        frame_no = 0;
        t0_prev = 0;
        t0_last = 0;
    endtask

    // mode 0: ch0 all ones, ch1 all zeros; mode 1: both channels alternate 1,0.
    task automatic drive_frames(input int nfr, input int mode, input int gap);
        for (int f = 0; f < nfr; f++) begin
            for (int b = 0; b < 32; b++) begin
                bif.valid_in = 1'b1;
                if (mode == 0) bif.din = 2'b01;
                else bif.din = (b % 2 == 0) ? 2'b11 : 2'b00;
                tick(1);
                bif.valid_in = 1'b0;
                if (b == 31) begin
                    frame_no++;
                    if (frame_no > 3 && !suppress) begin
                        if (mode == 0) begin
                            q.push_back('{1'b0, 16'sh7FFF});
                            q.push_back('{1'b1, 16'sh8000});
                        end else begin
                            q.push_back('{1'b0, 16'sh0000});
                            q.push_back('{1'b1, 16'sh0000});
                        end
                    end
                end
                tick(gap);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || bif.valid_out) && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) begin
            checks++;
            fails++;
            $display("FAIL %s_drain: got %0d samples outstanding, required 0", name, q.size());
        end
        tick(8);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ovr_clr      = 1'b0;
        bif.valid_in = 1'b0;
        bif.din      = 2'b00;
        bif.ready_in = 1'b1;
        tick(3);
        check("rst_valid_out", int'(bif.valid_out), 0);
        check("rst_dout", int'(bif.dout), 0);
        check("rst_dout_ch", int'(bif.dout_ch), 0);
        check("rst_overrun", int'(overrun), 0);
        do_reset();

        // 1: constant full-scale inputs, saturation of ch0
        drive_frames(6, 0, 0);
        wait_drain("t1");
        check("t1_rate", t0_last - t0_prev, 32);

        // 2: alternating inputs settle to zero
        do_reset();
        drive_frames(6, 1, 0);
        wait_drain("t2");
        check("t2_overrun", int'(overrun), 0);

        // 3: valid_in every third cycle
        do_reset();
        drive_frames(6, 0, 2);
        wait_drain("t3");
        check("t3_rate", t0_last - t0_prev, 96);

        // 4: backpressure fills the FIFO, third frame dropped; clear collides with the drop
        do_reset();
        bif.ready_in = 1'b0;
        drive_frames(5, 0, 0);
        tick(5);
        check("t4_no_ovr_at_full", int'(overrun), 0);
        drive_frames(1, 0, 0);
        q.pop_back();
        q.pop_back();
        ovr_clr = 1'b1;
        tick(3);
        ovr_clr = 1'b0;
        check("t4_ovr_set_wins", int'(overrun), 1);
        tick(4);
        bif.ready_in = 1'b1;
        wait_drain("t4");
        check("t4_ovr_sticky", int'(overrun), 1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        check("t4_ovr_clr", int'(overrun), 0);

        // 5: long stall with valid_out held
        do_reset();
        drive_frames(3, 0, 0);
        bif.ready_in = 1'b0;
        drive_frames(1, 0, 0);
        begin
            int n;
            n = 0;
            while (!bif.valid_out && n < 20) begin
                tick(1);
                n++;
            end
            check("t5_valid_seen", int'(bif.valid_out), 1);
        end
        tick(10);
        bif.ready_in = 1'b1;
        wait_drain("t5");

        // 6: reset during COMB(1) of a live frame, then cold-start equivalence
        do_reset();
        drive_frames(4, 0, 0);
        wait_drain("t6a");
        suppress = 1'b1;
        drive_frames(1, 0, 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("t6_valid_after_rst", int'(bif.valid_out), 0);
        reset = 1'b0;
        frame_no = 0;
        suppress = 1'b0;
        drive_frames(4, 0, 0);
        wait_drain("t6b");
        check("t6_overrun", int'(overrun), 0);
        check("final_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
